// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a ROWS x COLS push-button matrix. One column is driven low at a time
//   for SCAN_DIV cycles, and the synchronized rows are sampled on the last dwell
//   cycle. The samples from a full sweep are reduced to NONE / ONE(code) / MULTI.
//   A single debounce counter, evaluated once per sweep, then accepts a press or a
//   release. Each accepted press produces one key code through a valid/ready
//   output register.
//
// Ports
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous, active-high reset
//   row_in     in   ROWS    raw row pins, active-low, asynchronous
//   col_out    out  COLS    column drive, active-low, exactly one bit low
//   key_code   out  CODE_W  row*COLS + col of the accepted key
//   key_valid  out  1       key event pending until key_ready
//   key_ready  in   1       consumer accepts when key_valid & key_ready
//   key_held   out  1       a debounced key is currently down
//   overflow   out  1       1-cycle pulse: press accepted while an event was pending
module keypad_scan_ctrl #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DB_COUNT = 4,
    parameter int unsigned CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CNT_W = $clog2(DB_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

    // Row synchronizer
    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_sync;

    // Scan position
    logic [COL_W-1:0]  col_idx;
    logic [DIV_W-1:0]  dwell;

    // Per-sweep accumulation: acc_n saturates at 2 (meaning MULTI)
    logic [1:0]        acc_n;
    logic [CODE_W-1:0] acc_code;

    // Debounce state
    state_t            state;
    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;

    // Combinational helpers
    logic              sample_c;
    logic              sweep_end_c;
    logic [COL_W-1:0]  next_col_c;
    logic [1:0]        col_hits_c;
    logic [CODE_W-1:0] col_code_c;
    logic [2:0]        sum_c;
    logic [1:0]        tot_n_c;
    logic [CODE_W-1:0] tot_code_c;
    logic              one_c;
    logic              match_c;

    // Scan timing
    always_comb begin
        sample_c    = (dwell == DIV_W'(SCAN_DIV - 1));
        sweep_end_c = sample_c && (col_idx == COL_W'(COLS - 1));
        next_col_c  = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
    end

    // Count the keys seen low in the column currently being sampled
    always_comb begin
        col_hits_c = 2'd0;
        col_code_c = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (!row_sync[r]) begin
                if (col_hits_c != 2'd2) begin
                    col_hits_c = col_hits_c + 2'd1;
                end
                col_code_c = CODE_W'(32'(r) * COLS + 32'(col_idx));
            end
        end
    end

    // Merge this column with the earlier columns of the sweep
    always_comb begin
        sum_c      = 3'(acc_n) + 3'(col_hits_c);
        tot_n_c    = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
        tot_code_c = (col_hits_c != 2'd0) ? col_code_c : acc_code;
        one_c      = (tot_n_c == 2'd1);
        match_c    = one_c && (tot_code_c == cand);
    end

    // Scanner, sweep accumulator, debounce FSM and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta  <= '1;
            row_sync  <= '1;
            col_idx   <= '0;
            dwell     <= '0;
            col_out   <= ~COLS'(1);
            acc_n     <= 2'd0;
            acc_code  <= '0;
            state     <= S_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            overflow <= 1'b0;

            // Consumer handshake; a new issue below may re-assert key_valid
            if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            // Dwell counter and column rotation, no gap cycles
            if (sample_c) begin
                dwell   <= '0;
                col_idx <= next_col_c;
                col_out <= ~(COLS'(1) << next_col_c);
            end else begin
                dwell <= dwell + DIV_W'(1);
            end

            // Accumulator restarts at every sweep boundary
            if (sample_c) begin
                if (sweep_end_c) begin
                    acc_n    <= 2'd0;
                    acc_code <= '0;
                end else begin
                    acc_n    <= tot_n_c;
                    acc_code <= tot_code_c;
                end
            end

            // Debounce, once per sweep
            if (sweep_end_c) begin
                case (state)
                    S_IDLE: begin
                        if (one_c) begin
                            state <= S_PRESS_DB;
                            cand  <= tot_code_c;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    S_PRESS_DB: begin
                        if (match_c) begin
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(DB_COUNT - 1)) begin
                                state    <= S_HELD;
                                key_held <= 1'b1;
                                // Pending unaccepted event keeps its code
                                if (key_valid && !key_ready) begin
                                    overflow <= 1'b1;
                                end else begin
                                    key_valid <= 1'b1;
                                    key_code  <= cand;
                                end
                            end
                        end else if (one_c) begin
                            cand <= tot_code_c;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                    S_HELD: begin
                        if (!match_c) begin
                            state <= S_REL_DB;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    S_REL_DB: begin
                        if (match_c) begin
                            // Release bounce: back to held, no new event
                            state <= S_HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(DB_COUNT - 1)) begin
                            state    <= S_IDLE;
                            cnt      <= '0;
                            key_held <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model driving row_in from a per-sweep
// pressed-key mask, and a sweep-level reference model of debounce and handshake.
module tb_keypad_scan_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DB_COUNT = 3;
    localparam int SWEEP    = COLS * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DB_COUNT (DB_COUNT),
        .CODE_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          t;
    logic [15:0] mask;
    bit          raw_mode;
    bit          ready;
    int          ov_seen;

    // Reference model state
    bit m_held;
    int m_cand;
    int m_run;
    int m_rel;
    bit m_kv;
    int m_kc;
    bit m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // -1 = no key, -2 = several keys, else the single key code
    function automatic int classify();
        int n;
        int k;
        n = 0;
        k = -1;
        if (raw_mode) return -2;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (mask[i]) begin
                n++;
                k = i;
            end
        end
        if (n == 0) return -1;
        if (n == 1) return k;
        return -2;
    endfunction

    task automatic model_reset();
        m_held = 0; m_cand = 0; m_run = 0; m_rel = 0;
        m_kv = 0; m_kc = 0; m_ov = 0;
    endtask

    // Effect of the rising edge that ends cycle t
    task automatic model_edge();
        bit kv_old;
        bit ev;
        int res;
        kv_old = m_kv;
        ev = 0;
        m_ov = 0;
        if (kv_old && ready) m_kv = 0;
        if ((t % SWEEP) == SWEEP - 1) begin
            res = classify();
            if (!m_held) begin
                if (res >= 0) begin
                    if (m_run > 0 && res == m_cand) m_run++;
                    else begin m_cand = res; m_run = 1; end
                end else begin
                    m_run = 0;
                end
                if (m_run == DB_COUNT) begin
                    m_held = 1; m_run = 0; m_rel = 0; ev = 1;
                end
            end else begin
                if (res == m_cand) m_rel = 0;
                else m_rel++;
                if (m_rel == DB_COUNT) begin
                    m_held = 0; m_rel = 0;
                end
            end
            if (ev) begin
                if (kv_old && !ready) m_ov = 1;
                else begin m_kv = 1; m_kc = m_cand; end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] ec;
        ec = 4'hF;
        ec[(t / SCAN_DIV) % COLS] = 1'b0;
        chk("col_out",   32'(col_out),   32'(ec));
        chk("key_valid", 32'(key_valid), 32'(m_kv));
        chk("key_code",  32'(key_code),  32'(m_kc));
        chk("key_held",  32'(key_held),  32'(m_held));
        chk("overflow",  32'(overflow),  32'(m_ov));
    endtask

    // One clock cycle: drive the keypad for the expected column, then check
    task automatic step();
        int col;
        col = (t / SCAN_DIV) % COLS;
        if (raw_mode) begin
            row_in = 4'hF;
            if ((t % SWEEP) < 8) row_in[2] = 1'b0;
        end else begin
            for (int r = 0; r < ROWS; r++) row_in[r] = !mask[r * COLS + col];
        end
        key_ready = ready;
        @(posedge clk);
        model_edge();
        t++;
        #1;
        check_all();
        if (overflow) ov_seen++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        key_ready = 1'b0;
        ready = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        model_reset();
        chk("rst_col_out",   32'(col_out),   32'h0000_000E);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_held",  32'(key_held),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_key_code",  32'(key_code),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        reset = 1'b1;
        row_in = 4'hF;
        key_ready = 1'b0;
        mask = '0;
        raw_mode = 0;
        ready = 0;
        ov_seen = 0;
        t = 0;
        model_reset();

        // 1: idle scan rotation
        do_reset(2);
        run_cycles(2 * SWEEP);

        // 2: key 9 pressed, event after 3rd sweep, held until accepted
        do_reset(1);
        mask = 16'(1) << 9;
        run_cycles(3 * SWEEP - 1);
        chk("t2_not_yet", 32'(key_valid), 32'd0);
        step();
        chk("t2_valid", 32'(key_valid), 32'd1);
        chk("t2_code",  32'(key_code),  32'd9);
        chk("t2_held",  32'(key_held),  32'd1);
        run_cycles(20);
        chk("t2_waits", 32'(key_valid), 32'd1);
        ready = 1;
        step();
        ready = 0;
        chk("t2_accepted", 32'(key_valid), 32'd0);
        run_cycles(SWEEP + 3);

        // 3: bouncing row never produces an event
        do_reset(1);
        mask = '0;
        raw_mode = 1;
        run_cycles(10 * SWEEP);
        raw_mode = 0;
        chk("t3_no_event", 32'(key_valid), 32'd0);
        chk("t3_no_held",  32'(key_held),  32'd0);

        // 4: two keys together are ignored
        do_reset(1);
        mask = (16'(1) << 9) | (16'(1) << 6);
        run_cycles(6 * SWEEP);
        chk("t4_no_event", 32'(key_valid), 32'd0);
        chk("t4_no_held",  32'(key_held),  32'd0);

        // 5: second press while first event pending -> overflow
        do_reset(1);
        ov_seen = 0;
        mask = 16'(1) << 9;
        run_cycles(3 * SWEEP);
        mask = '0;
        run_cycles(3 * SWEEP);
        chk("t5_released", 32'(key_held), 32'd0);
        mask = 16'(1) << 0;
        run_cycles(3 * SWEEP);
        run_cycles(4);
        chk("t5_ov_pulses", 32'(ov_seen),   32'd1);
        chk("t5_code_kept", 32'(key_code),  32'd9);
        chk("t5_valid",     32'(key_valid), 32'd1);
        chk("t5_held",      32'(key_held),  32'd1);

        // 6: reset mid-debounce discards progress
        do_reset(1);
        mask = 16'(1) << 9;
        run_cycles(2 * SWEEP + 5);
        do_reset(1);
        run_cycles(3 * SWEEP - 1);
        chk("t6_not_yet", 32'(key_valid), 32'd0);
        step();
        chk("t6_valid", 32'(key_valid), 32'd1);
        chk("t6_code",  32'(key_code),  32'd9);

        // Random sweeps against the reference model
        do_reset(1);
        mask = '0;
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 9))
                6: mask = '0;
                7, 8: mask = 16'(1) << $urandom_range(0, 15);
                9: begin
                    a = int'($urandom_range(0, 15));
                    b = (a + int'($urandom_range(1, 15))) % 16;
                    mask = (16'(1) << a) | (16'(1) << b);
                end
                default: ;
            endcase
            for (int c = 0; c < SWEEP; c++) begin
                ready = ($urandom_range(0, 5) == 0);
                step();
            end
        end
        ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
